// File: rtl/regfile_2w_sb.sv
// regfile_2w_sb: parametrised register file with two write ports, two
// combinational read ports (optional same-cycle write bypass), a per-register
// busy scoreboard, and a sweep engine that zeroes the file on request.
module regfile_2w_sb #(
  parameter int WORD_SIZE    = 32,
  parameter int ADDRESS_SIZE = 4,
  parameter int BYPASS       = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDRESS_SIZE-1:0] src1,
  input  logic [ADDRESS_SIZE-1:0] src2,
  output logic [WORD_SIZE-1:0]    reg1,
  output logic [WORD_SIZE-1:0]    reg2,
  output logic                    busy1,
  output logic                    busy2,
  input  logic                    writeBackEn,
  input  logic [ADDRESS_SIZE-1:0] Dest_wb,
  input  logic [WORD_SIZE-1:0]    Result_WB,
  input  logic                    wr2_en,
  input  logic [ADDRESS_SIZE-1:0] wr2_addr,
  input  logic [WORD_SIZE-1:0]    wr2_data,
  input  logic                    issue_en,
  input  logic [ADDRESS_SIZE-1:0] issue_dest,
  input  logic                    clear_req,
  output logic                    ready
);

  localparam int DEPTH = 1 << ADDRESS_SIZE;
  localparam logic [ADDRESS_SIZE-1:0] ZERO_IDX = ADDRESS_SIZE'(0);
  localparam logic [ADDRESS_SIZE-1:0] ONE_IDX  = ADDRESS_SIZE'(1);
  localparam logic [ADDRESS_SIZE-1:0] LAST_IDX = ADDRESS_SIZE'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  logic [WORD_SIZE-1:0]    mem_q [DEPTH];
  logic [WORD_SIZE-1:0]    mem_d [DEPTH];
  logic [DEPTH-1:0]        busy_q;
  logic [DEPTH-1:0]        busy_d;
  state_e                  state_q;
  state_e                  state_d;
  logic [ADDRESS_SIZE-1:0] cnt_q;
  logic [ADDRESS_SIZE-1:0] cnt_d;
  logic                    idle_s;

  assign idle_s = (state_q == ST_IDLE);
  assign ready  = idle_s;

  // Read mux for one port: write-port forwarding only while idle and only
  // when bypass is enabled; port A takes priority over port B, R0 reads 0.
  function automatic logic [WORD_SIZE-1:0] read_mux(
    input logic [ADDRESS_SIZE-1:0] src,
    input logic                    fwd_ok,
    input logic                    a_en,
    input logic [ADDRESS_SIZE-1:0] a_addr,
    input logic [WORD_SIZE-1:0]    a_data,
    input logic                    b_en,
    input logic [ADDRESS_SIZE-1:0] b_addr,
    input logic [WORD_SIZE-1:0]    b_data,
    input logic [WORD_SIZE-1:0]    stored
  );
    logic [WORD_SIZE-1:0] res;
    if (src == ZERO_IDX) begin
      res = '0;
    end else if (fwd_ok && a_en && (a_addr == src)) begin
      res = a_data;
    end else if (fwd_ok && b_en && (b_addr == src)) begin
      res = b_data;
    end else begin
      res = stored;
    end
    return res;
  endfunction

  // Combinational read ports and scoreboard lookups (busy has no bypass).
  always_comb begin
    logic fwd_s;
    fwd_s = (BYPASS != 0) && idle_s;
    reg1  = read_mux(src1, fwd_s, writeBackEn, Dest_wb, Result_WB,
                     wr2_en, wr2_addr, wr2_data, mem_q[src1]);
    reg2  = read_mux(src2, fwd_s, writeBackEn, Dest_wb, Result_WB,
                     wr2_en, wr2_addr, wr2_data, mem_q[src2]);
    busy1 = busy_q[src1];
    busy2 = busy_q[src2];
  end

  // Next-state: idle writes/scoreboard updates and sweep sequencing.
  always_comb begin
    mem_d   = mem_q;
    busy_d  = busy_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        for (int i = 1; i < DEPTH; i++) begin
          logic a_hit;
          logic b_hit;
          logic iss_hit;
          a_hit   = writeBackEn && (Dest_wb == ADDRESS_SIZE'(i));
          b_hit   = wr2_en && (wr2_addr == ADDRESS_SIZE'(i));
          iss_hit = issue_en && (issue_dest == ADDRESS_SIZE'(i));
          // Port A wins a same-address collision.
          if (a_hit) begin
            mem_d[i] = Result_WB;
          end else if (b_hit) begin
            mem_d[i] = wr2_data;
          end else begin
            mem_d[i] = mem_q[i];
          end
          // A newly issued producer outranks a retiring write.
          if (iss_hit) begin
            busy_d[i] = 1'b1;
          end else if (a_hit || b_hit) begin
            busy_d[i] = 1'b0;
          end else begin
            busy_d[i] = busy_q[i];
          end
        end
        if (clear_req) begin
          state_d = ST_SWEEP;
          cnt_d   = ONE_IDX;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = cnt_q;
        end
      end
      ST_SWEEP: begin
        mem_d[cnt_q]  = '0;
        busy_d[cnt_q] = 1'b0;
        // Stop on the last index so the counter never wraps to 0 mid-sweep.
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          cnt_d   = ZERO_IDX;
        end else begin
          state_d = ST_SWEEP;
          cnt_d   = cnt_q + ONE_IDX;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = ZERO_IDX;
      end
    endcase
    mem_d[0]  = '0;
    busy_d[0] = 1'b0;
  end

  // State registers with asynchronous reset to an empty, idle file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q  <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= ZERO_IDX;
    end else begin
      mem_q   <= mem_d;
      busy_q  <= busy_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_regfile_2w_sb.sv
// Self-checking bench for regfile_2w_sb: directed test-plan steps followed by
// random traffic, checked against an array-based model of the register file.
`timescale 1ns/1ps
module tb_regfile_2w_sb;

  logic        clk;
  logic        rst;
  logic [3:0]  src1, src2;
  logic        writeBackEn, wr2_en, issue_en, clear_req;
  logic [3:0]  Dest_wb, wr2_addr, issue_dest;
  logic [31:0] Result_WB, wr2_data;

  logic [31:0] r1_b, r2_b, r1_n, r2_n;
  logic        bz1_b, bz2_b, bz1_n, bz2_n, rdy_b, rdy_n;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_mem  [16];
  logic        m_busy [16];
  bit          m_sweep;
  int          m_pos;

  regfile_2w_sb #(.WORD_SIZE(32), .ADDRESS_SIZE(4), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .reg1(r1_b), .reg2(r2_b),
    .busy1(bz1_b), .busy2(bz2_b), .writeBackEn(writeBackEn), .Dest_wb(Dest_wb),
    .Result_WB(Result_WB), .wr2_en(wr2_en), .wr2_addr(wr2_addr), .wr2_data(wr2_data),
    .issue_en(issue_en), .issue_dest(issue_dest), .clear_req(clear_req), .ready(rdy_b)
  );

  regfile_2w_sb #(.WORD_SIZE(32), .ADDRESS_SIZE(4), .BYPASS(0)) u_nob (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .reg1(r1_n), .reg2(r2_n),
    .busy1(bz1_n), .busy2(bz2_n), .writeBackEn(writeBackEn), .Dest_wb(Dest_wb),
    .Result_WB(Result_WB), .wr2_en(wr2_en), .wr2_addr(wr2_addr), .wr2_data(wr2_data),
    .issue_en(issue_en), .issue_dest(issue_dest), .clear_req(clear_req), .ready(rdy_n)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    writeBackEn = 1'b0; Dest_wb  = 4'd0; Result_WB = 32'd0;
    wr2_en      = 1'b0; wr2_addr = 4'd0; wr2_data  = 32'd0;
    issue_en    = 1'b0; issue_dest = 4'd0; clear_req = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_mem[i]  = 32'd0;
      m_busy[i] = 1'b0;
    end
    m_sweep = 1'b0;
    m_pos   = 0;
  endtask

  // Apply one clock edge's worth of architectural effect to the model.
  task automatic model_step();
    if (m_sweep) begin
      m_mem[m_pos]  = 32'd0;
      m_busy[m_pos] = 1'b0;
      m_pos++;
      if (m_pos == 16) m_sweep = 1'b0;
    end else begin
      if (wr2_en && wr2_addr != 4'd0) begin
        m_mem[wr2_addr]  = wr2_data;
        m_busy[wr2_addr] = 1'b0;
      end
      if (writeBackEn && Dest_wb != 4'd0) begin
        m_mem[Dest_wb]  = Result_WB;
        m_busy[Dest_wb] = 1'b0;
      end
      if (issue_en && issue_dest != 4'd0) m_busy[issue_dest] = 1'b1;
      if (clear_req) begin
        m_sweep = 1'b1;
        m_pos   = 1;
      end
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [3:0] src, input bit byp);
    if (src == 4'd0) return 32'd0;
    if (byp && !m_sweep && writeBackEn && Dest_wb == src) return Result_WB;
    if (byp && !m_sweep && wr2_en && wr2_addr == src) return wr2_data;
    return m_mem[src];
  endfunction

  task automatic check_now();
    chk("rd1_byp",  r1_b, exp_read(src1, 1'b1));
    chk("rd2_byp",  r2_b, exp_read(src2, 1'b1));
    chk("rd1_nob",  r1_n, exp_read(src1, 1'b0));
    chk("rd2_nob",  r2_n, exp_read(src2, 1'b0));
    chk("busy1_byp", {31'd0, bz1_b}, {31'd0, m_busy[src1]});
    chk("busy2_byp", {31'd0, bz2_b}, {31'd0, m_busy[src2]});
    chk("busy1_nob", {31'd0, bz1_n}, {31'd0, m_busy[src1]});
    chk("busy2_nob", {31'd0, bz2_n}, {31'd0, m_busy[src2]});
    chk("ready_byp", {31'd0, rdy_b}, {31'd0, !m_sweep});
    chk("ready_nob", {31'd0, rdy_n}, {31'd0, !m_sweep});
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic tick();
    #1 check_now();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Without any clock edge: every entry reads 0, no busy bits, ready high.
  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 16; i++) begin
      src1 = 4'(i);
      src2 = 4'(15 - i);
      #1;
      chk({tag, "_r1"}, r1_b, 32'd0);
      chk({tag, "_r2"}, r2_n, 32'd0);
      chk({tag, "_b1"}, {31'd0, bz1_b}, 32'd0);
      chk({tag, "_b2"}, {31'd0, bz2_n}, 32'd0);
    end
    chk({tag, "_rdy_b"}, {31'd0, rdy_b}, 32'd1);
    chk({tag, "_rdy_n"}, {31'd0, rdy_n}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    src1 = 4'd0; src2 = 4'd0;
    idle_inputs();
    model_reset();
    #20 check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    // Two writes in one cycle
    writeBackEn = 1'b1; Dest_wb = 4'd3; Result_WB = 32'h12345678;
    wr2_en = 1'b1; wr2_addr = 4'd5; wr2_data = 32'hCAFEF00D;
    src1 = 4'd3; src2 = 4'd5;
    tick();
    idle_inputs();
    #1 chk("dual_wr_r3", r1_n, 32'h12345678);
    chk("dual_wr_r5", r2_n, 32'hCAFEF00D);
    tick();

    // Same-address collision: port A wins
    writeBackEn = 1'b1; Dest_wb = 4'd7; Result_WB = 32'h1;
    wr2_en = 1'b1; wr2_addr = 4'd7; wr2_data = 32'h2;
    tick();
    idle_inputs();
    src1 = 4'd7;
    #1 chk("collision_r7", r1_n, 32'h1);
    tick();

    // Writes to R0 are dropped
    writeBackEn = 1'b1; Dest_wb = 4'd0; Result_WB = 32'hFFFFFFFF;
    src1 = 4'd0;
    #1 chk("r0_same_cycle", r1_b, 32'd0);
    tick();
    idle_inputs();
    #1 chk("r0_after", r1_n, 32'd0);
    tick();

    // Bypass vs no bypass
    writeBackEn = 1'b1; Dest_wb = 4'd4; Result_WB = 32'hAA;
    src1 = 4'd4;
    #1 chk("bypass_on", r1_b, 32'hAA);
    chk("bypass_off_old", r1_n, 32'd0);
    tick();
    idle_inputs();
    #1 chk("bypass_off_new", r1_n, 32'hAA);
    tick();

    // Scoreboard: issue, clear by write, issue-beats-write
    issue_en = 1'b1; issue_dest = 4'd6; src1 = 4'd6;
    #1 chk("busy_no_bypass", {31'd0, bz1_b}, 32'd0);
    tick();
    idle_inputs();
    #1 chk("busy_set", {31'd0, bz1_b}, 32'd1);
    wr2_en = 1'b1; wr2_addr = 4'd6; wr2_data = 32'h55;
    tick();
    idle_inputs();
    #1 chk("busy_cleared", {31'd0, bz1_b}, 32'd0);
    issue_en = 1'b1; issue_dest = 4'd6;
    writeBackEn = 1'b1; Dest_wb = 4'd6; Result_WB = 32'h66;
    tick();
    idle_inputs();
    #1 chk("busy_issue_wins", {31'd0, bz1_b}, 32'd1);
    tick();

    // Sweep: fill, clear, watch in-order zeroing, dropped write mid-sweep
    for (int i = 1; i < 16; i++) begin
      writeBackEn = 1'b1; Dest_wb = 4'(i); Result_WB = 32'h1000_0000 + 32'(i);
      issue_en = (i == 15); issue_dest = 4'd9;
      src1 = 4'(i); src2 = 4'd9;
      tick();
    end
    idle_inputs();
    clear_req = 1'b1;
    tick();
    idle_inputs();
    for (int k = 1; k < 16; k++) begin
      src1 = 4'(k); src2 = 4'(k - 1);
      if (k == 3) begin
        writeBackEn = 1'b1; Dest_wb = 4'd2; Result_WB = 32'hDEAD;
      end else begin
        writeBackEn = 1'b0;
      end
      #1 chk("sweep_ready_low", {31'd0, rdy_b}, 32'd0);
      tick();
    end
    idle_inputs();
    #1 chk("sweep_done_ready", {31'd0, rdy_b}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      src1 = 4'(i); src2 = 4'(i);
      #1 chk("sweep_zero", r1_n, 32'd0);
      chk("sweep_busy_zero", {31'd0, bz2_b}, 32'd0);
    end
    @(negedge clk);

    // Async reset in the middle of a sweep
    for (int i = 1; i < 16; i++) begin
      wr2_en = 1'b1; wr2_addr = 4'(i); wr2_data = 32'hB000_0000 + 32'(i);
      tick();
    end
    idle_inputs();
    issue_en = 1'b1; issue_dest = 4'd12;
    tick();
    idle_inputs();
    clear_req = 1'b1;
    tick();
    idle_inputs();
    for (int k = 1; k <= 4; k++) begin
      src1 = 4'(k); src2 = 4'd12;
      tick();
    end
    rst = 1'b1;
    check_reset_state("async_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      writeBackEn = 1'($urandom_range(0, 1));
      Dest_wb     = 4'($urandom_range(0, 15));
      Result_WB   = $urandom;
      wr2_en      = 1'($urandom_range(0, 1));
      wr2_addr    = ($urandom_range(0, 3) == 0) ? Dest_wb : 4'($urandom_range(0, 15));
      wr2_data    = $urandom;
      issue_en    = 1'($urandom_range(0, 1));
      issue_dest  = 4'($urandom_range(0, 15));
      clear_req   = ($urandom_range(0, 39) == 0);
      src1        = ($urandom_range(0, 2) == 0) ? Dest_wb : 4'($urandom_range(0, 15));
      src2        = ($urandom_range(0, 2) == 0) ? wr2_addr : 4'($urandom_range(0, 15));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
